// File: rtl/game_io_pkg.sv
// game_io_pkg: shared definitions for the pushbutton front end.
// Holds the per-button FSM state type, the button index constants and the
// default timing constants, sized for a 50 MHz clock.
package game_io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_LOGIC_0  = 0;
    localparam int BTN_LOGIC_1  = 1;
    localparam int BTN_ACTIVITY = 2;
    localparam int NUM_BUTTONS  = 3;

    // 20 ms debounce and 0.5 s auto-repeat at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

    // One counter serves both the debounce and the repeat timing, so it is
    // sized for the larger of the two.
    function automatic int counter_width(input int debounce_cycles, input int repeat_cycles);
        return $clog2(((debounce_cycles > repeat_cycles) ? debounce_cycles : repeat_cycles) + 1);
    endfunction

endpackage

// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm: one pushbutton channel.
// Synchronizes the raw active-low pin, debounces it with a four-state FSM and
// a saturating counter, reports the debounced level (held) and emits a
// one-cycle press_event when a press is accepted.
// Optional feature macro: BUTTON_AUTOREPEAT_EN -- when defined and REPEAT_EN
// is set, a button held in PRESSED re-issues press_event every REPEAT_CYCLES.
module button_debounce_fsm
    import game_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clock_builtin_50MHZ,
    input  logic not_reset,
    input  logic not_pin,
    output logic held,
    output logic press_event
);

    localparam int CNT_W = counter_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             sync_meta_reg;
    logic             sync_reg;
    btn_state_t       state_reg;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    // Counter never wraps: it parks at all-ones if ever left running.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    // Two-flop synchronizer; idles high so reset looks like "not pressed".
    always_ff @(posedge clock_builtin_50MHZ or negedge not_reset) begin
        if (!not_reset) begin
            sync_meta_reg <= 1'b1;
            sync_reg      <= 1'b1;
        end else begin
            sync_meta_reg <= not_pin;
            sync_reg      <= sync_meta_reg;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock_builtin_50MHZ or negedge not_reset) begin
        if (!not_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Debounce transitions; press_event fires on the cycle a press qualifies.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        press_event = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!sync_reg) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_reg) begin
                    state_next = IDLE;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next  = PRESSED;
                    cnt_next    = '0;
                    press_event = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            PRESSED: begin
                if (sync_reg) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
`ifdef BUTTON_AUTOREPEAT_EN
                else if (REPEAT_EN) begin
                    if (cnt_reg == REP_LAST) begin
                        cnt_next    = '0;
                        press_event = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                if (!sync_reg) begin
                    // Bounce on release: back to PRESSED without a new press.
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign held = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

endmodule

// File: rtl/button_input_conditioner.sv
// button_input_conditioner: three debounced pushbuttons feeding the game logic.
// Each accepted press sets a pending flag; a registered priority arbiter
// (logic_0 > logic_1 > activity) turns at most one flag per cycle into an
// active-low one-cycle pulse, so simultaneous presses come out back to back.
// Optional feature macro: BUTTON_AUTOREPEAT_EN -- auto-repeat for logic_0 and
// logic_1 while held; activity never repeats.
module button_input_conditioner
    import game_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic       clock_builtin_50MHZ,
    input  logic       not_reset,
    input  logic       not_logic_0_pin,
    input  logic       not_logic_1_pin,
    input  logic       not_activity_pin,
    output logic       not_logic_0,
    output logic       not_logic_1,
    output logic       not_activity,
    output logic [2:0] held
);

    logic [NUM_BUTTONS-1:0] raw_pin_n;
    logic [NUM_BUTTONS-1:0] press_event;
    logic [NUM_BUTTONS-1:0] pending_reg;
    logic [NUM_BUTTONS-1:0] pending_next;
    logic [NUM_BUTTONS-1:0] grant_reg;
    logic [NUM_BUTTONS-1:0] grant_next;

    assign raw_pin_n[BTN_LOGIC_0]  = not_logic_0_pin;
    assign raw_pin_n[BTN_LOGIC_1]  = not_logic_1_pin;
    assign raw_pin_n[BTN_ACTIVITY] = not_activity_pin;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_button
            button_debounce_fsm #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_CYCLES  (REPEAT_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
                ,
                .REPEAT_EN      (gi != BTN_ACTIVITY)
`endif
            ) u_debounce (
                .clock_builtin_50MHZ(clock_builtin_50MHZ),
                .not_reset          (not_reset),
                .not_pin            (raw_pin_n[gi]),
                .held               (held[gi]),
                .press_event        (press_event[gi])
            );
        end
    endgenerate

    // Priority pick of one pending flag; new presses OR in so a flag that is
    // already waiting is not counted twice and an unserved one is never lost.
    always_comb begin
        grant_next = '0;
        if (pending_reg[BTN_LOGIC_0]) begin
            grant_next[BTN_LOGIC_0] = 1'b1;
        end else if (pending_reg[BTN_LOGIC_1]) begin
            grant_next[BTN_LOGIC_1] = 1'b1;
        end else if (pending_reg[BTN_ACTIVITY]) begin
            grant_next[BTN_ACTIVITY] = 1'b1;
        end
        pending_next = (pending_reg & ~grant_next) | press_event;
    end

    // Pending flags and registered output pulses.
    always_ff @(posedge clock_builtin_50MHZ or negedge not_reset) begin
        if (!not_reset) begin
            pending_reg <= '0;
            grant_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            grant_reg   <= grant_next;
        end
    end

    assign not_logic_0  = ~grant_reg[BTN_LOGIC_0];
    assign not_logic_1  = ~grant_reg[BTN_LOGIC_1];
    assign not_activity = ~grant_reg[BTN_ACTIVITY];

endmodule

// File: tb/tb_button_input_conditioner.sv
// Testbench for button_input_conditioner (DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64).
// A run-length reference model predicts accepted presses and the arbitrated
// pulse order; a monitor pops and compares each observed pulse.
// Honors BUTTON_AUTOREPEAT_EN when it is defined for the build.
module tb_button_input_conditioner;

    localparam int D = 16;
    localparam int R = 64;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] pin_n = 3'b111;
    logic       o0;
    logic       o1;
    logic       o2;
    logic [2:0] held;

    button_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clock_builtin_50MHZ(clk),
        .not_reset          (rst_n),
        .not_logic_0_pin    (pin_n[0]),
        .not_logic_1_pin    (pin_n[1]),
        .not_activity_pin   (pin_n[2]),
        .not_logic_0        (o0),
        .not_logic_1        (o1),
        .not_activity       (o2),
        .held               (held)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int btn;
        int edge_n;
    } pulse_t;

    pulse_t     exp_q[$];
    int         cyc = 0;
    bit [2:0]   acc;           // accepted (debounced) level, 1 = pressed
    int         run[3];        // consecutive samples disagreeing with acc
    int         rep[3];        // cycles spent steadily pressed
    bit [2:0]   pend;
    bit [2:0]   d1;
    bit [2:0]   d2;
    bit [2:0]   smp;
    bit [2:0]   newp;
    int         served;
    int         pulse_cnt[3];
    int         last_edge[3];

    // Reference model: the pin is seen two edges late; the accepted level
    // flips after D+1 consecutive disagreeing samples; each new press (and
    // each repeat period) queues one pulse; lowest index wins each cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  = '0;
            pend = '0;
            d1   = '1;
            d2   = '1;
            exp_q.delete();
            for (int b = 0; b < 3; b++) begin
                run[b] = 0;
                rep[b] = 0;
            end
        end else begin
            cyc++;
            smp  = d2;
            d2   = d1;
            d1   = pin_n;
            newp = '0;
            for (int b = 0; b < 3; b++) begin
                if (smp[b] == acc[b]) begin
                    run[b]++;
                    if (run[b] == D + 1) begin
                        acc[b]  = ~acc[b];
                        run[b]  = 0;
                        rep[b]  = 0;
                        newp[b] = acc[b];
                    end
                end else begin
                    if (acc[b] && run[b] > 0) begin
                        rep[b] = 0;
                    end else if (acc[b] && AR && b != 2) begin
                        rep[b]++;
                        if (rep[b] == R) begin
                            newp[b] = 1'b1;
                            rep[b]  = 0;
                        end
                    end
                    run[b] = 0;
                end
            end
            served = -1;
            for (int b = 0; b < 3; b++) begin
                if (served < 0 && pend[b]) served = b;
            end
            if (served >= 0) begin
                exp_q.push_back('{btn: served, edge_n: cyc});
                pend[served] = 1'b0;
            end
            pend = pend | newp;
        end
    end

    // Monitor: compare the level outputs every cycle and each pulse against the queue.
    always @(negedge clk) begin
        logic [2:0] lows;
        pulse_t     e;
        if (!rst_n) begin
            checks++;
            if ({o2, o1, o0} !== 3'b111 || held !== 3'b000) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d pulses_n=%b held=%b required pulses_n=111 held=000",
                         cyc, {o2, o1, o0}, held);
            end
        end else begin
            checks++;
            if (held !== acc) begin
                failures++;
                $display("FAIL held cyc=%0d actual=%b required=%b", cyc, held, acc);
            end
            while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_pulse cyc=%0d actual=none required=btn%0d@%0d", cyc, e.btn, e.edge_n);
            end
            lows = ~{o2, o1, o0};
            if (lows != 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d actual=%b required=none", cyc, lows);
                end else begin
                    e = exp_q.pop_front();
                    if (lows != (3'b001 << e.btn) || e.edge_n != cyc) begin
                        failures++;
                        $display("FAIL pulse cyc=%0d actual=%b required=btn%0d@%0d", cyc, lows, e.btn, e.edge_n);
                    end
                end
                for (int b = 0; b < 3; b++) begin
                    if (lows[b]) begin
                        pulse_cnt[b]++;
                        last_edge[b] = cyc;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    initial begin
        int k;
        int m;
        int c0;
        for (int b = 0; b < 3; b++) begin
            pulse_cnt[b] = 0;
            last_edge[b] = -1;
        end
        rst_n = 1'b0;
        pin_n = 3'b111;
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // Clean 40-cycle press of logic_0
        c0 = pulse_cnt[0];
        k  = cyc;
        pin_n[0] = 1'b0;
        tick(40);
        pin_n[0] = 1'b1;
        tick(30);
        check("clean_press_count", pulse_cnt[0] - c0, 1);
        check("clean_press_edge", last_edge[0], k + 20);

        // Chatter on logic_1, never stable long enough
        c0 = pulse_cnt[1];
        for (int i = 0; i < 20; i++) begin
            pin_n[1] = ~pin_n[1];
            tick(5);
        end
        pin_n[1] = 1'b1;
        tick(30);
        check("chatter_count", pulse_cnt[1] - c0, 0);

        // All three pressed together: consecutive pulses in priority order
        k = cyc;
        pin_n = 3'b000;
        tick(40);
        check("all3_edge_logic_0", last_edge[0], k + 20);
        check("all3_edge_logic_1", last_edge[1], k + 21);
        check("all3_edge_activity", last_edge[2], k + 22);
        pin_n = 3'b111;
        tick(30);

        // Held press with a 3-cycle high glitch
        c0 = pulse_cnt[2];
        pin_n[2] = 1'b0;
        tick(30);
        pin_n[2] = 1'b1;
        tick(3);
        pin_n[2] = 1'b0;
        tick(30);
        pin_n[2] = 1'b1;
        tick(30);
        check("glitch_count", pulse_cnt[2] - c0, 1);

        // Reset in the middle of PRESS_WAIT while still holding
        c0 = pulse_cnt[1];
        pin_n[1] = 1'b0;
        tick(13);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        m = cyc;
        tick(40);
        check("reset_mid_count", pulse_cnt[1] - c0, 1);
        check("reset_mid_edge", last_edge[1], m + 20);
        pin_n[1] = 1'b1;
        tick(30);

        // Long holds: logic_1 repeats when enabled, activity never does
        c0 = pulse_cnt[1];
        pin_n[1] = 1'b0;
        tick(200);
        pin_n[1] = 1'b1;
        tick(30);
        check("long_hold_logic_1", pulse_cnt[1] - c0, AR ? 3 : 1);
        c0 = pulse_cnt[2];
        pin_n[2] = 1'b0;
        tick(200);
        pin_n[2] = 1'b1;
        tick(30);
        check("long_hold_activity", pulse_cnt[2] - c0, 1);

        // Random pin patterns with one reset dropped in mid-run
        for (int s = 0; s < 80; s++) begin
            pin_n = 3'($urandom_range(0, 7));
            tick($urandom_range(1, 30));
            if (s == 40) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
        end
        pin_n = 3'b111;
        tick(40);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
